instruction_encode: RTL

- Inverse of the instruction decoder: takes decoded fields (one-hot opcode class, register indices, subfunctions, 32-bit immediate) and produces a 32-bit RV32I instruction word.
- Used by the debug/test-program injector and the boot loader to build instruction streams. The stream is fed to the instruction fetch path.
- Registered, with valid/ready on both sides. Optionally expands a load-immediate pseudo-op into an LUI/ADDI pair.

---
 rtl/instruction_encode_pkg.sv | 69 ++++++
 rtl/instruction_encode_word.sv | 105 ++++++++++
 rtl/instruction_encode.sv | 97 +++++++++
 3 files changed

// File: rtl/instruction_encode_pkg.sv
// Shared RV32I encoder definitions: opcodes, one-hot class indices, FSM states, field packers.
package instruction_encode_pkg;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
  localparam logic [6:0] OPCODE_DEBUG  = 7'b1110011;

  localparam int ONEHOT_LUI_INDEX    = 0;
  localparam int ONEHOT_AUIPC_INDEX  = 1;
  localparam int ONEHOT_JAL_INDEX    = 2;
  localparam int ONEHOT_JALR_INDEX   = 3;
  localparam int ONEHOT_BRANCH_INDEX = 4;
  localparam int ONEHOT_LOAD_INDEX   = 5;
  localparam int ONEHOT_STORE_INDEX  = 6;
  localparam int ONEHOT_ITYPE_INDEX  = 7;
  localparam int ONEHOT_RTYPE_INDEX  = 8;
  localparam int ONEHOT_FENCE_INDEX  = 9;
  localparam int ONEHOT_DEBUG_INDEX  = 10;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL,
    ST_FULL_PENDING
  } enc_state_e;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  // imm[0] is implied zero for branches and jumps, so it is not part of the word.
  function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] op);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] upper, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {upper, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
  endfunction

endpackage

// File: rtl/instruction_encode_word.sv
// Combinational fields-to-word encoder with immediate range checking.
// Optional LI expansion into LUI/ADDI under INSTR_ENCODE_LI_EXPANSION_EN.
module instruction_encode_word
  import instruction_encode_pkg::*;
#(
  parameter int OPCODE_SEL_WIDTH = 11
) (
  input  logic [OPCODE_SEL_WIDTH-1:0] opcode_selection,
  input  logic                        load_immediate,
  input  logic [4:0]                  destination_reg,
  input  logic [4:0]                  source_reg_1,
  input  logic [4:0]                  source_reg_2,
  input  logic [2:0]                  subfunction_3,
  input  logic [6:0]                  subfunction_7,
  input  logic [31:0]                 immediate,
  output logic [31:0]                 word,
  output logic                        encoding_error,
  output logic [31:0]                 second_word,
  output logic                        has_second
);

  logic onehot;
  logic fits_12;
  logic fits_13;
  logic fits_21;

  assign onehot  = (opcode_selection != '0) &&
                   ((opcode_selection & (opcode_selection - 1'b1)) == '0);
  assign fits_12 = (immediate[31:11] == '0) || (immediate[31:11] == '1);
  assign fits_13 = (immediate[31:12] == '0) || (immediate[31:12] == '1);
  assign fits_21 = (immediate[31:20] == '0) || (immediate[31:20] == '1);

`ifdef INSTR_ENCODE_LI_EXPANSION_EN
  // (imm + 0x800) >> 12 without carrying the unused low bits around.
  logic [19:0] li_upper;
  assign li_upper = immediate[31:12] + {19'd0, immediate[11]};
`endif

  always_comb begin
    word           = '0;
    encoding_error = 1'b0;
    second_word    = '0;
    has_second     = 1'b0;
    if (load_immediate) begin
`ifdef INSTR_ENCODE_LI_EXPANSION_EN
      if (fits_12) begin
        word = enc_i(immediate[11:0], 5'd0, 3'd0, destination_reg, OPCODE_ITYPE);
      end else begin
        word = enc_u(li_upper, destination_reg, OPCODE_LUI);
        if (immediate[11:0] != '0) begin
          has_second  = 1'b1;
          second_word = enc_i(immediate[11:0], destination_reg, 3'd0, destination_reg,
                              OPCODE_ITYPE);
        end
      end
`else
      word           = enc_i(immediate[11:0], 5'd0, 3'd0, destination_reg, OPCODE_ITYPE);
      encoding_error = !fits_12;
`endif
    end else if (!onehot) begin
      encoding_error = 1'b1;
    end else if (opcode_selection[ONEHOT_LUI_INDEX]) begin
      word           = enc_u(immediate[31:12], destination_reg, OPCODE_LUI);
      encoding_error = immediate[11:0] != '0;
    end else if (opcode_selection[ONEHOT_AUIPC_INDEX]) begin
      word           = enc_u(immediate[31:12], destination_reg, OPCODE_AUIPC);
      encoding_error = immediate[11:0] != '0;
    end else if (opcode_selection[ONEHOT_JAL_INDEX]) begin
      word           = enc_j(immediate[20:1], destination_reg, OPCODE_JAL);
      encoding_error = !fits_21 || immediate[0];
    end else if (opcode_selection[ONEHOT_JALR_INDEX]) begin
      word           = enc_i(immediate[11:0], source_reg_1, subfunction_3, destination_reg,
                             OPCODE_JALR);
      encoding_error = !fits_12;
    end else if (opcode_selection[ONEHOT_BRANCH_INDEX]) begin
      word           = enc_b(immediate[12:1], source_reg_2, source_reg_1, subfunction_3,
                             OPCODE_BRANCH);
      encoding_error = !fits_13 || immediate[0];
    end else if (opcode_selection[ONEHOT_LOAD_INDEX]) begin
      word           = enc_i(immediate[11:0], source_reg_1, subfunction_3, destination_reg,
                             OPCODE_LOAD);
      encoding_error = !fits_12;
    end else if (opcode_selection[ONEHOT_STORE_INDEX]) begin
      word           = enc_s(immediate[11:0], source_reg_2, source_reg_1, subfunction_3,
                             OPCODE_STORE);
      encoding_error = !fits_12;
    end else if (opcode_selection[ONEHOT_ITYPE_INDEX]) begin
      word           = enc_i(immediate[11:0], source_reg_1, subfunction_3, destination_reg,
                             OPCODE_ITYPE);
      encoding_error = !fits_12;
    end else if (opcode_selection[ONEHOT_RTYPE_INDEX]) begin
      word = enc_r(subfunction_7, source_reg_2, source_reg_1, subfunction_3, destination_reg,
                   OPCODE_RTYPE);
    end else if (opcode_selection[ONEHOT_FENCE_INDEX]) begin
      word           = enc_i(immediate[11:0], source_reg_1, subfunction_3, destination_reg,
                             OPCODE_FENCE);
      encoding_error = !fits_12;
    end else if (opcode_selection[ONEHOT_DEBUG_INDEX]) begin
      word           = enc_i(immediate[11:0], source_reg_1, subfunction_3, destination_reg,
                             OPCODE_DEBUG);
      encoding_error = !fits_12;
    end
  end

endmodule

// File: rtl/instruction_encode.sv
// Registered RV32I instruction encoder with valid/ready on both sides.
// LI pseudo-op expansion is enabled by INSTR_ENCODE_LI_EXPANSION_EN (see instruction_encode_word).
module instruction_encode
  import instruction_encode_pkg::*;
#(
  parameter int OPCODE_SEL_WIDTH = 11
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [OPCODE_SEL_WIDTH-1:0] in_opcode_selection,
  input  logic                        in_load_immediate,
  input  logic [4:0]                  in_destination_reg,
  input  logic [4:0]                  in_source_reg_1,
  input  logic [4:0]                  in_source_reg_2,
  input  logic [2:0]                  in_subfunction_3,
  input  logic [6:0]                  in_subfunction_7,
  input  logic [31:0]                 in_immediate,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_instruction,
  output logic                        out_encoding_error,
  output logic                        out_last
);

  enc_state_e  state;
  logic [31:0] word;
  logic        word_error;
  logic [31:0] second_word;
  logic        has_second;
  logic [31:0] pending_word;
  logic        accept;
  logic        out_fire;

  instruction_encode_word #(
    .OPCODE_SEL_WIDTH(OPCODE_SEL_WIDTH)
  ) u_word (
    .opcode_selection(in_opcode_selection),
    .load_immediate  (in_load_immediate),
    .destination_reg (in_destination_reg),
    .source_reg_1    (in_source_reg_1),
    .source_reg_2    (in_source_reg_2),
    .subfunction_3   (in_subfunction_3),
    .subfunction_7   (in_subfunction_7),
    .immediate       (in_immediate),
    .word            (word),
    .encoding_error  (word_error),
    .second_word     (second_word),
    .has_second      (has_second)
  );

  assign in_ready = (state == ST_EMPTY) || ((state == ST_FULL) && out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= ST_EMPTY;
      out_valid          <= 1'b0;
      out_instruction    <= '0;
      out_encoding_error <= 1'b0;
      out_last           <= 1'b0;
      pending_word       <= '0;
    end else begin
      case (state)
        ST_EMPTY, ST_FULL: begin
          if (accept) begin
            out_valid          <= 1'b1;
            out_instruction    <= word;
            out_encoding_error <= word_error;
            out_last           <= !has_second;
            pending_word       <= second_word;
            state              <= has_second ? ST_FULL_PENDING : ST_FULL;
          end else if (out_fire) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_FULL_PENDING: begin
          if (out_fire) begin
            out_instruction    <= pending_word;
            out_encoding_error <= 1'b0;
            out_last           <= 1'b1;
            pending_word       <= '0;
            state              <= ST_FULL;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule
